serializer_buffered: RTL and testbench

SERIALIZER_BUFFERED -- requirements
Module: serializer_buffered

---
 rtl/serializer_buffered_pkg.sv | 14 +
 rtl/serializer_buffered_if.sv | 28 ++
 rtl/serializer_buffered_fifo.sv | 60 ++++++
 rtl/serializer_buffered.sv | 121 ++++++++++++
 tb/tb_serializer_buffered.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/serializer_buffered_pkg.sv
// rtl/serializer_buffered_pkg.sv - shared defaults and shifter state type for the buffered serializer
package serializer_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_DEPTH     = 4;
  localparam int DEF_MIN_LEN   = 3;
  localparam int DEF_MSB_FIRST = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

endpackage

// File: rtl/serializer_buffered_if.sv
// rtl/serializer_buffered_if.sv - parallel word input handshake into the serializer
interface serializer_buffered_if
  import serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MOD_W  = $clog2(DATA_W)
);

  logic [DATA_W-1:0] data_i;
  logic [MOD_W-1:0]  data_mod_i;
  logic              data_val_i;
  logic              data_rdy_o;

  modport master (
    output data_i,
    output data_mod_i,
    output data_val_i,
    input  data_rdy_o
  );

  modport slave (
    input  data_i,
    input  data_mod_i,
    input  data_val_i,
    output data_rdy_o
  );

endinterface

// File: rtl/serializer_buffered_fifo.sv
// rtl/serializer_buffered_fifo.sv - show-ahead word FIFO with registered not-full ready
module ser_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             rdy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             rdy_q;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is legal when the head leaves in the same cycle.
  assign do_rd   = rd_i && (cnt_q != '0);
  assign do_wr   = wr_i && ((cnt_q != CW'(DEPTH)) || do_rd);
  assign cnt_d   = cnt_q + CW'(do_wr) - CW'(do_rd);
  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (cnt_q == '0);
  assign rdy_o   = rdy_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/serializer_buffered.sv
// rtl/serializer_buffered.sv - buffers parallel words with a bit length and shifts them out serially
module serializer_buffered
  import serializer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MOD_W     = $clog2(DATA_W),
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MIN_LEN   = DEF_MIN_LEN,
  parameter int MSB_FIRST = DEF_MSB_FIRST
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  serializer_buffered_if.slave  in_if,
  output logic                  ser_data_o,
  output logic                  ser_data_val_o,
  output logic                  ser_last_o,
  output logic                  busy_o
);

  // One extra bit so a full-width burst length fits.
  localparam int LEN_W  = MOD_W + 1;
  localparam int FIFO_W = LEN_W + DATA_W;

  logic [LEN_W-1:0]  in_len;
  logic              in_legal;
  logic              fifo_wr;
  logic              fifo_rd;
  logic              fifo_empty;
  logic              fifo_rdy;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [DATA_W-1:0] head_data;
  logic [LEN_W-1:0]  head_len;

  shift_state_e      state_q;
  logic [DATA_W-1:0] sh_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              ser_data_q;
  logic              ser_val_q;
  logic              ser_last_q;
  logic              cur_bit;
  logic [DATA_W-1:0] sh_next;
  logic              last_bit;

  assign in_len   = (in_if.data_mod_i == '0) ? LEN_W'(DATA_W) : {1'b0, in_if.data_mod_i};
  assign in_legal = (in_len >= LEN_W'(MIN_LEN));
  // Too-short words are still handshaken so the source never stalls on them.
  assign fifo_wr  = !srst_i && in_if.data_val_i && fifo_rdy && in_legal;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LEN_W'(1));
  assign fifo_rd  = !srst_i && !fifo_empty && ((state_q == ST_IDLE) || last_bit);

  assign head_len  = fifo_rdata[FIFO_W-1 -: LEN_W];
  assign head_data = fifo_rdata[DATA_W-1:0];

  assign cur_bit = (MSB_FIRST != 0) ? sh_q[DATA_W-1] : sh_q[0];
  assign sh_next = (MSB_FIRST != 0) ? {sh_q[DATA_W-2:0], 1'b0} : {1'b0, sh_q[DATA_W-1:1]};

  ser_word_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .wr_i    (fifo_wr),
    .wdata_i ({in_len, in_if.data_i}),
    .rd_i    (fifo_rd),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .rdy_o   (fifo_rdy)
  );

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q    <= ST_IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      ser_last_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ser_data_q <= 1'b0;
          ser_val_q  <= 1'b0;
          ser_last_q <= 1'b0;
          if (!fifo_empty) begin
            sh_q    <= head_data;
            cnt_q   <= head_len;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          ser_data_q <= cur_bit;
          ser_val_q  <= 1'b1;
          ser_last_q <= last_bit;
          // Reloading on the final bit keeps consecutive bursts gap-free.
          if (last_bit) begin
            if (!fifo_empty) begin
              sh_q  <= head_data;
              cnt_q <= head_len;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end else begin
            sh_q  <= sh_next;
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_if.data_rdy_o = fifo_rdy;
  assign ser_data_o       = ser_data_q;
  assign ser_data_val_o   = ser_val_q;
  assign ser_last_o       = ser_last_q;
  assign busy_o           = !fifo_empty || (state_q == ST_SHIFT) || ser_val_q;

endmodule

// File: tb/tb_serializer_buffered.sv
// tb/tb_serializer_buffered.sv - directed scoreboard bench for serializer_buffered (MSB and LSB first)
module tb_serializer_buffered;

  logic clk = 1'b0;
  logic srst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serializer_buffered_if #(.DATA_W(16)) a_if ();
  serializer_buffered_if #(.DATA_W(16)) b_if ();

  logic a_ser, a_sval, a_last, a_busy;
  logic b_ser, b_sval, b_last, b_busy;

  serializer_buffered #(.DATA_W(16), .DEPTH(4), .MIN_LEN(3), .MSB_FIRST(1)) dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .in_if          (a_if),
    .ser_data_o     (a_ser),
    .ser_data_val_o (a_sval),
    .ser_last_o     (a_last),
    .busy_o         (a_busy)
  );

  serializer_buffered #(.DATA_W(16), .DEPTH(4), .MIN_LEN(3), .MSB_FIRST(0)) dut_lsb (
    .clk_i          (clk),
    .srst_i         (srst),
    .in_if          (b_if),
    .ser_data_o     (b_ser),
    .ser_data_val_o (b_sval),
    .ser_last_o     (b_last),
    .busy_o         (b_busy)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];

  logic mon_en = 1'b0;
  int   a_bits = 0, a_run = 0, a_max_run = 0, a_rise = -1, a_last_cyc = -1;
  int   b_rise = -1;
  logic a_prev = 1'b0, b_prev = 1'b0;
  int   acc_cyc;
  logic saw_full;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: every valid bit must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_sval) begin
        a_bits++;
        a_run++;
        if (a_run > a_max_run) a_max_run = a_run;
        if (!a_prev) a_rise = cyc;
        check("a_bit_expected", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) check("a_bit", {a_ser, a_last}, qa.pop_front());
        if (a_last) a_last_cyc = cyc;
      end else begin
        a_run = 0;
        check("a_idle_zero", {a_ser, a_last}, 0);
      end
      if (b_sval) begin
        if (!b_prev) b_rise = cyc;
        check("b_bit_expected", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) check("b_bit", {b_ser, b_last}, qb.pop_front());
      end else begin
        check("b_idle_zero", {b_ser, b_last}, 0);
      end
      a_prev = a_sval;
      b_prev = b_sval;
    end
  end

  task automatic send(input int which, input logic [15:0] d, input logic [3:0] m);
    int   lenv;
    logic acc;
    logic rdy;
    lenv = (m == 4'd0) ? 16 : int'(m);
    if (which == 0) begin
      a_if.data_i = d; a_if.data_mod_i = m; a_if.data_val_i = 1'b1;
    end else begin
      b_if.data_i = d; b_if.data_mod_i = m; b_if.data_val_i = 1'b1;
    end
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      rdy = (which == 0) ? a_if.data_rdy_o : b_if.data_rdy_o;
      if (!rdy) saw_full = 1'b1;
      @(posedge clk); #1;
      acc = rdy;
    end
    check("send_accept", 32'(acc), 1);
    acc_cyc = cyc;
    if (lenv >= 3) begin
      for (int i = 0; i < lenv; i++) begin
        if (which == 0) qa.push_back({d[15-i], (i == lenv - 1)});
        else            qb.push_back({d[i],    (i == lenv - 1)});
      end
    end
  endtask

  task automatic idle();
    a_if.data_val_i = 1'b0;
    b_if.data_val_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (qa.size() == 0 && qb.size() == 0 && !a_busy && !b_busy) break;
    end
    check(tag, 32'(qa.size() + qb.size()), 0);
  endtask

  initial begin
    int base;
    int seen;
    int busy_lo;

    // Reset with a valid word presented: it must be ignored.
    srst = 1'b1;
    a_if.data_i = 16'hFFFF; a_if.data_mod_i = 4'd0; a_if.data_val_i = 1'b1;
    b_if.data_i = 16'hFFFF; b_if.data_mod_i = 4'd0; b_if.data_val_i = 1'b1;
    saw_full = 1'b0;
    @(posedge clk); #1;
    check("rst_ser_data", 32'(a_ser), 0);
    check("rst_ser_val", 32'(a_sval), 0);
    check("rst_ser_last", 32'(a_last), 0);
    check("rst_busy", 32'(a_busy), 0);
    check("rst_rdy", 32'(a_if.data_rdy_o), 1);
    mon_en = 1'b1;
    @(posedge clk); #1;
    srst = 1'b0;
    idle();
    @(posedge clk); #1;
    check("rst_ignored_busy", 32'(a_busy), 0);

    // Single full-width word, MSB first, three-edge latency.
    send(0, 16'hA5C3, 4'd0);
    idle();
    base = acc_cyc;
    drain("single_drain");
    check("single_latency", 32'(a_rise), 32'(base + 2));
    check("single_last_cyc", 32'(a_last_cyc), 32'(base + 2 + 15));

    // Lengths 1 and 2 are dropped; length 3 emits 111.
    base = a_bits;
    send(0, 16'hE000, 4'd1);
    send(0, 16'hE000, 4'd2);
    send(0, 16'hE000, 4'd3);
    idle();
    busy_lo = -1;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (!a_busy) begin
        busy_lo = cyc;
        break;
      end
    end
    check("short_latency", 32'(a_rise), 32'(acc_cyc + 2));
    check("short_bits", 32'(a_bits - base), 3);
    check("short_busy_fall", 32'(busy_lo), 32'(a_last_cyc + 1));
    drain("short_drain");

    // Six 4-bit words with valid held high: backpressure and gap-free bursts.
    saw_full = 1'b0;
    base = a_bits;
    send(0, 16'h9000, 4'd4);
    send(0, 16'hA000, 4'd4);
    send(0, 16'h3000, 4'd4);
    send(0, 16'hC000, 4'd4);
    send(0, 16'h5000, 4'd4);
    send(0, 16'h6000, 4'd4);
    idle();
    drain("full_drain");
    check("full_rdy_dropped", 32'(saw_full), 1);
    check("full_bits", 32'(a_bits - base), 24);
    check("full_no_gaps", 32'(a_max_run), 24);
    check("full_rdy_back", 32'(a_if.data_rdy_o), 1);

    // LSB-first instance.
    send(1, 16'h0001, 4'd5);
    idle();
    base = acc_cyc;
    drain("lsb_drain");
    check("lsb_latency", 32'(b_rise), 32'(base + 2));
    send(1, 16'hA5C3, 4'd0);
    idle();
    drain("lsb_full_drain");

    // Reset seven bits into a 16-bit burst with two words buffered.
    send(0, 16'hBEEF, 4'd0);
    send(0, 16'h1357, 4'd0);
    send(0, 16'hC0DE, 4'd0);
    idle();
    seen = 0;
    for (int t = 0; t < 100; t++) begin
      if (a_sval) seen++;
      if (seen == 7) break;
      @(posedge clk); #1;
    end
    check("mid_seen_bits", 32'(seen), 7);
    srst = 1'b1;
    @(posedge clk); #1;
    qa.delete();
    check("mid_rst_ser_data", 32'(a_ser), 0);
    check("mid_rst_ser_val", 32'(a_sval), 0);
    check("mid_rst_ser_last", 32'(a_last), 0);
    check("mid_rst_busy", 32'(a_busy), 0);
    check("mid_rst_rdy", 32'(a_if.data_rdy_o), 1);
    srst = 1'b0;
    @(posedge clk); #1;
    check("mid_flushed_busy", 32'(a_busy), 0);
    send(0, 16'h1234, 4'd0);
    idle();
    base = acc_cyc;
    drain("post_rst_drain");
    check("post_rst_latency", 32'(a_rise), 32'(base + 2));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
